// File: rtl/e_mdu_sched_pkg.sv
// Shared encodings and small helpers for the E-stage multiply/divide scheduler.
// The madd/maddu/msub/msubu encodings are always reserved here; whether they
// start an operation is decided in e_mdu_sched by the MDU_MADD_EN macro.
package e_mdu_sched_pkg;

    localparam int unsigned MDU_OP_W = 4;
    localparam int unsigned XLEN     = 32;

    // Decoded E-stage MDU op encodings, shared with the control decoder
    localparam logic [MDU_OP_W-1:0] MDU_NONE  = 4'd0;
    localparam logic [MDU_OP_W-1:0] MDU_MULT  = 4'd1;
    localparam logic [MDU_OP_W-1:0] MDU_MULTU = 4'd2;
    localparam logic [MDU_OP_W-1:0] MDU_DIV   = 4'd3;
    localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 4'd4;
    localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 4'd5;
    localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 4'd6;
    localparam logic [MDU_OP_W-1:0] MDU_MFHI  = 4'd7;
    localparam logic [MDU_OP_W-1:0] MDU_MFLO  = 4'd8;
    localparam logic [MDU_OP_W-1:0] MDU_MADD  = 4'd9;
    localparam logic [MDU_OP_W-1:0] MDU_MADDU = 4'd10;
    localparam logic [MDU_OP_W-1:0] MDU_MSUB  = 4'd11;
    localparam logic [MDU_OP_W-1:0] MDU_MSUBU = 4'd12;

    // Scheduler FSM states
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Ops that always start a multi-cycle operation
    function automatic logic is_base_start(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    // Multiply-accumulate family (only honoured when the feature is built in)
    function automatic logic is_madd_op(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_MADD) || (op == MDU_MADDU) ||
               (op == MDU_MSUB) || (op == MDU_MSUBU);
    endfunction

    // Two's-complement magnitude of a 32-bit value
    function automatic logic [XLEN-1:0] mag32(input logic [XLEN-1:0] v);
        return v[XLEN-1] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/e_mdu_sched.sv
// E-stage multiply/divide scheduler: computes the result in the start cycle,
// holds it in temp registers, and commits it to HI/LO after a fixed latency.
// Optional feature macro: MDU_MADD_EN (madd/maddu/msub/msubu accumulate into {HI,LO}).
module e_mdu_sched
    import e_mdu_sched_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Req,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUout
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      temp_hi_q, temp_hi_d;
    logic [31:0]      temp_lo_q, temp_lo_d;

    logic             busy_q;
    logic             is_start;
    logic             start_ok;
    logic             is_div_op;
    logic [CNT_W-1:0] start_cnt;

    logic [63:0]      prod_s, prod_u;
    logic [31:0]      abs_a, abs_b, div_s_den, q_mag, r_mag, q_s, r_s;
    logic [31:0]      div_u_den, q_u, r_u;
    logic [31:0]      res_hi, res_lo;

    assign busy_q = (state_q == ST_BUSY);

`ifdef MDU_MADD_EN
    assign is_start = is_base_start(MDUop) || is_madd_op(MDUop);
`else
    assign is_start = is_base_start(MDUop);
`endif

    assign start_ok  = is_start && !Req && !busy_q;
    assign is_div_op = (MDUop == MDU_DIV) || (MDUop == MDU_DIVU);
    assign start_cnt = is_div_op ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    // Products: sign-extending to 64 bits makes the low 64 bits the signed product
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide on magnitudes so min/-1 wraps cleanly; a zero divisor is masked to 1
    assign abs_a     = mag32(A);
    assign abs_b     = mag32(B);
    assign div_s_den = (B == 32'd0) ? 32'd1 : abs_b;
    assign q_mag     = abs_a / div_s_den;
    assign r_mag     = abs_a % div_s_den;
    assign q_s       = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
    assign r_s       = A[31] ? (~r_mag + 32'd1) : r_mag;

    assign div_u_den = (B == 32'd0) ? 32'd1 : B;
    assign q_u       = A / div_u_den;
    assign r_u       = A % div_u_den;

    // Result datapath feeding the temp registers
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (MDUop)
            MDU_MULT:  {res_hi, res_lo} = prod_s;
            MDU_MULTU: {res_hi, res_lo} = prod_u;
            MDU_DIV: begin
                res_lo = (B == 32'd0) ? 32'hFFFF_FFFF : q_s;
                res_hi = (B == 32'd0) ? A : r_s;
            end
            MDU_DIVU: begin
                res_lo = (B == 32'd0) ? 32'hFFFF_FFFF : q_u;
                res_hi = (B == 32'd0) ? A : r_u;
            end
`ifdef MDU_MADD_EN
            MDU_MADD:  {res_hi, res_lo} = {hi_q, lo_q} + prod_s;
            MDU_MADDU: {res_hi, res_lo} = {hi_q, lo_q} + prod_u;
            MDU_MSUB:  {res_hi, res_lo} = {hi_q, lo_q} - prod_s;
            MDU_MSUBU: {res_hi, res_lo} = {hi_q, lo_q} - prod_u;
`endif
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

    // Next-state: IDLE accepts starts and moves-to; BUSY counts down and commits
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        temp_hi_d = temp_hi_q;
        temp_lo_d = temp_lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    temp_hi_d = res_hi;
                    temp_lo_d = res_lo;
                    cnt_d     = start_cnt;
                    state_d   = ST_BUSY;
                end else if (!Req && (MDUop == MDU_MTHI)) begin
                    hi_d = A;
                end else if (!Req && (MDUop == MDU_MTLO)) begin
                    lo_d = A;
                end
            end
            ST_BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = temp_hi_q;
                    lo_d    = temp_lo_q;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous reset; reset discards any in-flight result
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            temp_hi_q <= 32'd0;
            temp_lo_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            temp_hi_q <= temp_hi_d;
            temp_lo_q <= temp_lo_d;
        end
    end

    assign Busy   = start_ok | busy_q;
    assign HI     = hi_q;
    assign LO     = lo_q;
    assign MDUout = (MDUop == MDU_MFHI) ? hi_q :
                    (MDUop == MDU_MFLO) ? lo_q : 32'd0;

endmodule
